// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-high, bit order gfedcba) and the slot phase type
// for the multiplexed 7-segment scanner.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {PH_BLANK, PH_ON} phase_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// 3-digit multiplexed 7-segment scanner: captures BCD digits on rdy, reloads the shown value
// only at frame start, and scans slots with a blank gap, leading-zero blanking and dash for invalid.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] fdig,
    input  logic [3:0] sdig,
    input  logic [3:0] tdig,
    input  logic       rdy,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_start,
    output logic       valid
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYC);

    logic [11:0]   shadow, disp;
    logic          valid_q, disp_vld;
    logic [1:0]    slot, slot_nxt;
    phase_t        phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    an_q;
    logic [6:0]    seg_q;
    logic          fs_q;

    logic          frame_entry, on_entry, lz_blank;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot  <= 2'd0;
            phase <= PH_BLANK;
            cnt   <= '0;
        end else begin
            slot  <= slot_nxt;
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        cnt_nxt   = cnt + 1'b1;
        slot_nxt  = slot;
        phase_nxt = phase;
        if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            phase_nxt = PH_BLANK;
            slot_nxt  = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end else if (cnt_nxt == CNT_ON) begin
            phase_nxt = PH_ON;
        end
    end

    assign frame_entry = (slot == 2'd0) && (phase == PH_BLANK) && (cnt == '0);
    assign on_entry    = (phase == PH_ON) && (cnt == CNT_ON);

    // Leading-zero blanking judges the displayed value, not the pending shadow.
    always_comb begin
        cur_digit = disp[3:0];
        lz_blank  = 1'b0;
        case (slot)
            2'd1: begin
                cur_digit = disp[7:4];
                lz_blank  = blank_lz && disp_vld && (disp[11:4] == 8'd0);
            end
            2'd2: begin
                cur_digit = disp[11:8];
                lz_blank  = blank_lz && disp_vld && (disp[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Outputs only move on phase entries, so mid-slot input changes never glitch the display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow   <= '0;
            disp     <= '0;
            valid_q  <= 1'b0;
            disp_vld <= 1'b0;
            an_q     <= 3'b000;
            seg_q    <= SEG_OFF;
            fs_q     <= 1'b0;
        end else begin
            fs_q <= frame_entry;
            if (frame_entry) begin
                disp     <= shadow;
                disp_vld <= valid_q;
            end
            if (cnt == '0) begin
                an_q  <= 3'b000;
                seg_q <= SEG_OFF;
            end else if (on_entry) begin
                if (lz_blank) begin
                    an_q  <= 3'b000;
                    seg_q <= SEG_OFF;
                end else begin
                    an_q  <= 3'b001 << slot;
                    seg_q <= disp_vld ? dec_seg : SEG_DASH;
                end
            end
            if (rdy) begin
                shadow  <= {tdig, sdig, fdig};
                valid_q <= 1'b1;
            end
        end
    end

    assign seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an          = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
    assign frame_start = fs_q;
    assign valid       = valid_q;

endmodule
